// File: rtl/fact_pkg.sv
// Shared constants and state type for the factorial controller.
package fact_pkg;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned N_W       = 6;
   localparam int unsigned MUL_STEPS = 6;
   localparam int unsigned DEF_MAX_N = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      NEXT = 2'd2,
      DONE = 2'd3
   } fact_state_e;

endpackage

// File: rtl/cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module cla64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        ci,
   output logic [63:0] sum,
   output logic        co
);

   logic [63:0] g;
   logic [63:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // Per group: local carries from the group carry-in, then group G/P forms the next carry-in.
   always_comb begin
      logic       cin;
      logic [3:0] gg;
      logic [3:0] pp;
      logic [3:0] c;
      sum = '0;
      cin = ci;
      for (int gi = 0; gi < 16; gi++) begin
         gg   = g[4*gi +: 4];
         pp   = p[4*gi +: 4];
         c[0] = cin;
         c[1] = gg[0] | (pp[0] & cin);
         c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
         c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cin);
         sum[4*gi +: 4] = pp ^ c;
         cin = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
               | (&pp & cin);
      end
      co = cin;
   end

endmodule

// File: rtl/fact_ctrl.sv
// Factorial sequencer: n! by shift-and-add multiplication through one shared cla64 adder.
module fact_ctrl
   import fact_pkg::*;
#(
   parameter int unsigned MAX_N = DEF_MAX_N
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              op_start,
   input  logic              op_clear,
   input  logic [N_W-1:0]    n_value,
   output logic [DATA_W-1:0] result,
   output logic              op_done,
   output logic              op_err,
   output logic              busy
);

   fact_state_e       state;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] p_q;
   logic [N_W-1:0]    k_q;
   logic [2:0]        i_q;
   logic [N_W-1:0]    n_q;
   logic [DATA_W-1:0] addend;
   logic [DATA_W-1:0] add_sum;

   // Shifted running product; bits pushed past bit 63 are dropped.
   always_comb begin
      addend = r_q << i_q;
   end

   cla64 u_cla64 (
      .a   (p_q),
      .b   (addend),
      .ci  (1'b0),
      .sum (add_sum),
      .co  ()
   );

   // Controller state, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         r_q     <= '0;
         p_q     <= '0;
         k_q     <= '0;
         i_q     <= '0;
         n_q     <= '0;
         result  <= '0;
         op_done <= 1'b0;
         op_err  <= 1'b0;
         busy    <= 1'b0;
      end else if (op_clear) begin
         state   <= IDLE;
         result  <= '0;
         op_done <= 1'b0;
         op_err  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               op_done <= 1'b0;
               if (op_start) begin
                  n_q    <= n_value;
                  r_q    <= DATA_W'(1);
                  p_q    <= '0;
                  k_q    <= N_W'(2);
                  i_q    <= '0;
                  result <= '0;
                  op_err <= 1'b0;
                  if (32'(n_value) > MAX_N) begin
                     state   <= DONE;
                     op_err  <= 1'b1;
                     op_done <= 1'b1;
                  end else if (n_value < N_W'(2)) begin
                     state   <= DONE;
                     result  <= DATA_W'(1);
                     op_done <= 1'b1;
                  end else begin
                     state <= MUL;
                     busy  <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (k_q[i_q]) begin
                  p_q <= add_sum;
               end
               if (i_q == 3'(MUL_STEPS - 1)) begin
                  i_q   <= '0;
                  state <= NEXT;
               end else begin
                  i_q <= i_q + 3'd1;
               end
            end
            NEXT: begin
               r_q <= p_q;
               p_q <= '0;
               k_q <= k_q + N_W'(1);
               if (k_q == n_q) begin
                  result  <= p_q;
                  state   <= DONE;
                  busy    <= 1'b0;
                  op_done <= 1'b1;
               end else begin
                  state <= MUL;
               end
            end
            DONE: begin
               op_done <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
